// File: rtl/mm_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the TX state encoding.
package mm_uart_tx_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_BAUD   = 4'hC;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_IRQ   = 3;
  localparam int STAT_OVF   = 4;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divider below 2 cannot time a bit, so it is raised to 2.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/mm_uart_tx_if.sv
// picorv32 native-bus slave port of the UART: select, strobes, offset and
// write data in; acknowledge and read data out.
interface mm_uart_tx_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (output select, wstrb, addr, data_i, input ready, data_o);
  modport slave  (input select, wstrb, addr, data_i, output ready, data_o);
endinterface

// File: rtl/mm_uart_tx_sync_fifo.sv
// Synchronous circular FIFO with extra-bit wrap pointers. A pop in the same
// cycle as a push to a full FIFO frees the slot first, so the push is kept.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register block, byte FIFO and a
// START/DATA/STOP shifter whose bit time is reloaded from BAUD_DIV per bit.
module mm_uart_tx
  import mm_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic          clk,
  input  logic          reset,
  mm_uart_tx_if.slave   bus,
  output logic          irq,
  output logic          tx
);
  logic        ready_q;
  logic [31:0] data_o_q;
  logic        tx_en_q, irq_en_q, overflow_q;
  logic [15:0] baud_div_q;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic        access_s, wr_en_s, rd_en_s, push_s, busy_s, start_ok_s;
  logic [3:0]  reg_off_s;
  logic [31:0] rdata_s;
  logic        fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_dout_s;
  logic        unused_bits;

  // One side effect per transaction: only the cycle before the ack acts.
  assign access_s   = bus.select & ~ready_q;
  assign wr_en_s    = access_s & (bus.wstrb != 4'h0);
  assign rd_en_s    = access_s & (bus.wstrb == 4'h0);
  assign reg_off_s  = {bus.addr[3:2], 2'b00};
  assign push_s     = wr_en_s & (reg_off_s == REG_DATA);
  assign busy_s     = (state_q != ST_IDLE);
  assign start_ok_s = tx_en_q & ~fifo_empty_s;

  assign irq         = irq_en_q & fifo_empty_s & ~busy_s;
  assign tx          = tx_q;
  assign bus.ready   = ready_q;
  assign bus.data_o  = data_o_q;
  assign unused_bits = ^{bus.addr[1:0], bus.data_i[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (fifo_pop_s),
    .din_i   (bus.data_i[7:0]),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  always_comb begin
    rdata_s = 32'h0000_0000;
    case (reg_off_s)
      REG_STATUS: begin
        rdata_s[STAT_BUSY]  = busy_s;
        rdata_s[STAT_FULL]  = fifo_full_s;
        rdata_s[STAT_EMPTY] = fifo_empty_s;
        rdata_s[STAT_IRQ]   = irq;
        rdata_s[STAT_OVF]   = overflow_q;
      end
      REG_CTRL: begin
        rdata_s[CTRL_TX_EN]  = tx_en_q;
        rdata_s[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_BAUD: rdata_s = {16'h0000, baud_div_q};
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      data_o_q   <= 32'h0000_0000;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      baud_div_q <= DEFAULT_DIV;
      overflow_q <= 1'b0;
    end else begin
      ready_q <= access_s;
      if (rd_en_s) data_o_q <= rdata_s;
      if (wr_en_s && reg_off_s == REG_CTRL) begin
        tx_en_q  <= bus.data_i[CTRL_TX_EN];
        irq_en_q <= bus.data_i[CTRL_IRQ_EN];
      end
      if (wr_en_s && reg_off_s == REG_BAUD) baud_div_q <= clamp_div(bus.data_i[15:0]);
      // A full FIFO only drops the byte when the shifter is not popping now.
      if (push_s && fifo_full_s && !fifo_pop_s) begin
        overflow_q <= 1'b1;
      end else if (wr_en_s && reg_off_s == REG_STATUS && bus.data_i[STAT_OVF]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // tx_d is the line level for the state being entered, keeping tx registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start_ok_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_dout_s;
          cnt_d      = baud_div_q - 16'd1;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          cnt_d   = baud_div_q - 16'd1;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = baud_div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (start_ok_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_dout_s;
            cnt_d      = baud_div_q - 16'd1;
            state_d    = ST_START;
            tx_d       = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
